mc_ctrl_unit: RTL

- Parametrised multicycle control unit for the 32-bit MIPS subset core: addu, subu, ori, lw, sw, beq, jal.
- Drives every PC, IR, RF, DM, ALU, extender, mux-select and intermediate-register enable in the datapath from a Moore FSM.
- New over the current controller: configurable memory wait states (fixed latency or ack handshake), illegal-op flag, and a retired-instruction counter.

---
 rtl/mc_ctrl_unit_pkg.sv | 81 ++++++++
 rtl/mc_ctrl_unit_mem_wait_timer.sv | 34 +++
 rtl/mc_ctrl_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_unit_pkg.sv
// mc_pkg: encodings shared by the multicycle controller and the datapath.
// Holds FSM state codes, decoded opcodes, ALU operations, every mux-select
// code and the packed bundle of controller outputs.
package mc_pkg;

  // FSM state codes (also visible on the debug state port)
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMCALC  = 4'd2;
  localparam logic [3:0] S_MEMLOAD  = 4'd3;
  localparam logic [3:0] S_MEMWRITE = 4'd4;
  localparam logic [3:0] S_REGWR    = 4'd5;
  localparam logic [3:0] S_REXEC    = 4'd6;
  localparam logic [3:0] S_RFIN     = 4'd7;
  localparam logic [3:0] S_OREXEC   = 4'd8;
  localparam logic [3:0] S_ORFIN    = 4'd9;
  localparam logic [3:0] S_BRFIN    = 4'd10;
  localparam logic [3:0] S_JAFIN    = 4'd11;

  // Decoded opcodes
  localparam logic [2:0] OP_ADDU = 3'd0;
  localparam logic [2:0] OP_SUBU = 3'd1;
  localparam logic [2:0] OP_ORI  = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_BEQ  = 3'd5;
  localparam logic [2:0] OP_JAL  = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  // ALU operations
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;

  // ALU operand A select
  localparam logic A_PC = 1'b0;
  localparam logic A_RA = 1'b1;

  // ALU operand B select
  localparam logic [1:0] B_FOUR  = 2'd0;
  localparam logic [1:0] B_RB    = 2'd1;
  localparam logic [1:0] B_EXTSH = 2'd2;
  localparam logic [1:0] B_EXT   = 2'd3;

  // Register-file write address select
  localparam logic [1:0] W_RT  = 2'd0;
  localparam logic [1:0] W_RD  = 2'd1;
  localparam logic [1:0] W_R31 = 2'd2;

  // Register-file write data select
  localparam logic [1:0] D_DR  = 2'd0;
  localparam logic [1:0] D_ALU = 2'd1;
  localparam logic [1:0] D_PC  = 2'd2;

  // Next-PC select
  localparam logic [1:0] P_TARGET = 2'd0;
  localparam logic [1:0] P_ALUOUT = 2'd1;
  localparam logic [1:0] P_JUMP   = 2'd2;

  // Every controller output except the debug state and the counter
  typedef struct packed {
    logic       mem_req;
    logic       pc_wr;
    logic       ir_wr;
    logic       ab_wr;
    logic       aluout_wr;
    logic       dr_wr;
    logic       target_wr;
    logic       dm_wr;
    logic       rf_wr;
    logic       illegal_op;
    logic       ext_sz;
    logic       alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [1:0] alu_ctrl;
    logic [1:0] rf_w_sel;
    logic [1:0] rf_din_sel;
    logic [1:0] pc_sel;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_unit_mem_wait_timer.sv
// mem_wait_timer: produces the memory-access done strobe.
// Ports:
//   clk, rst (sync, active-low)
//   mem_req  in  : a memory access is in progress this cycle
//   mem_ack  in  : memory completion (only looked at when USE_ACK=1)
//   done     out : the current access completes this cycle
// With USE_ACK=0 an access lasts MEM_LAT+1 cycles; wait_cnt restarts from 0
// whenever an access completes or no access is in progress.
module mem_wait_timer #(
  parameter int MEM_LAT = 0,
  parameter int USE_ACK = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic mem_ack,
  output logic done
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  logic [3:0] wait_cnt;
  logic       lat_done;

  assign lat_done = (wait_cnt == LAT);
  // done is qualified by mem_req so a stray ack outside an access is ignored
  assign done = mem_req & ((USE_ACK != 0) ? mem_ack : lat_done);

  always_ff @(posedge clk) begin
    if (!rst || !mem_req || done) wait_cnt <= '0;
    else                          wait_cnt <= wait_cnt + 4'd1;
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// mc_ctrl_unit: Moore-style multicycle controller for the MIPS subset
// (addu, subu, ori, lw, sw, beq, jal).
// Ports:
//   clk, rst (sync, active-low)
//   op [2:0]          decoded opcode (7 = illegal)
//   zf                ALU zero flag (branch decision)
//   mem_ack           memory completion, USE_ACK=1 only
//   mem_req           memory access in progress
//   *_wr, dm_wr       register / memory write enables
//   ext_sz, alu_*_sel, alu_ctrl, rf_w_sel, rf_din_sel, pc_sel  datapath selects
//   illegal_op        one-cycle pulse when an illegal opcode is decoded
//   state [3:0]       current FSM state, for debug
//   retired [CNT_W-1:0] completed-instruction count, wraps
module mc_ctrl_unit
  import mc_pkg::*;
#(
  parameter int MEM_LAT = 0,
  parameter int USE_ACK = 0,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic             zf,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic             ab_wr,
  output logic             aluout_wr,
  output logic             dr_wr,
  output logic             target_wr,
  output logic             dm_wr,
  output logic             rf_wr,
  output logic             ext_sz,
  output logic             alu_a_sel,
  output logic [1:0]       alu_b_sel,
  output logic [1:0]       alu_ctrl,
  output logic [1:0]       rf_w_sel,
  output logic [1:0]       rf_din_sel,
  output logic [1:0]       pc_sel,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  logic [3:0] nxt;
  logic       retire;
  logic       req;
  logic       done;
  ctrl_t      c;
  ctrl_t      o;

  // Decoded from state alone so the timer's done has no path back into req
  assign req = (state == S_FETCH) || (state == S_MEMLOAD) || (state == S_MEMWRITE);

  mem_wait_timer #(
    .MEM_LAT (MEM_LAT),
    .USE_ACK (USE_ACK)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .mem_req (req),
    .mem_ack (mem_ack),
    .done    (done)
  );

  always_comb begin
    nxt    = S_FETCH;
    retire = 1'b0;
    case (state)
      S_FETCH:    nxt = done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_ADDU, OP_SUBU: nxt = S_REXEC;
          OP_ORI:           nxt = S_OREXEC;
          OP_LW, OP_SW:     nxt = S_MEMCALC;
          OP_BEQ:           nxt = S_BRFIN;
          OP_JAL:           nxt = S_JAFIN;
          default:          nxt = S_FETCH;   // illegal: abandon, no retire
        endcase
      end
      S_MEMCALC:  nxt = (op == OP_SW) ? S_MEMWRITE : S_MEMLOAD;
      S_MEMLOAD:  nxt = done ? S_REGWR : S_MEMLOAD;
      S_MEMWRITE: begin
        nxt    = done ? S_FETCH : S_MEMWRITE;
        retire = done;
      end
      S_REXEC:    nxt = S_RFIN;
      S_OREXEC:   nxt = S_ORFIN;
      S_REGWR, S_RFIN, S_ORFIN, S_BRFIN, S_JAFIN: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      default:    nxt = S_FETCH;
    endcase
  end

  always_comb begin
    c         = '0;
    c.mem_req = req;
    case (state)
      S_FETCH: begin
        c.alu_a_sel = A_PC;
        c.alu_b_sel = B_FOUR;
        c.alu_ctrl  = ALU_ADD;
        c.pc_sel    = P_ALUOUT;
        c.ir_wr     = done;
        c.pc_wr     = done;
      end
      S_DECODE: begin
        // Branch target PC+4+(imm<<2) is computed here speculatively
        c.ab_wr      = 1'b1;
        c.target_wr  = 1'b1;
        c.alu_a_sel  = A_PC;
        c.alu_b_sel  = B_EXTSH;
        c.ext_sz     = 1'b1;
        c.alu_ctrl   = ALU_ADD;
        c.illegal_op = (op == OP_ILL);
      end
      S_MEMCALC: begin
        c.alu_a_sel = A_RA;
        c.alu_b_sel = B_EXT;
        c.ext_sz    = 1'b1;
        c.alu_ctrl  = ALU_ADD;
        c.aluout_wr = 1'b1;
      end
      S_MEMLOAD:  c.dr_wr = done;
      S_MEMWRITE: c.dm_wr = done;
      S_REGWR: begin
        c.rf_wr      = 1'b1;
        c.rf_w_sel   = W_RT;
        c.rf_din_sel = D_DR;
      end
      S_REXEC: begin
        c.alu_a_sel = A_RA;
        c.alu_b_sel = B_RB;
        c.alu_ctrl  = (op == OP_SUBU) ? ALU_SUB : ALU_ADD;
        c.aluout_wr = 1'b1;
      end
      S_RFIN: begin
        c.rf_wr      = 1'b1;
        c.rf_w_sel   = W_RD;
        c.rf_din_sel = D_ALU;
      end
      S_OREXEC: begin
        c.alu_a_sel = A_RA;
        c.alu_b_sel = B_EXT;
        c.ext_sz    = 1'b0;
        c.alu_ctrl  = ALU_OR;
        c.aluout_wr = 1'b1;
      end
      S_ORFIN: begin
        c.rf_wr      = 1'b1;
        c.rf_w_sel   = W_RT;
        c.rf_din_sel = D_ALU;
      end
      S_BRFIN: begin
        c.alu_a_sel = A_RA;
        c.alu_b_sel = B_RB;
        c.alu_ctrl  = ALU_SUB;
        c.pc_sel    = P_TARGET;
        c.pc_wr     = zf;
      end
      S_JAFIN: begin
        // PC already holds PC+4 from FETCH, which is the link value
        c.rf_wr      = 1'b1;
        c.rf_w_sel   = W_R31;
        c.rf_din_sel = D_PC;
        c.pc_wr      = 1'b1;
        c.pc_sel     = P_JUMP;
      end
      default: c = '0;
    endcase
  end

  // Everything is held quiet while reset is asserted
  assign o = rst ? c : '0;

  assign mem_req    = o.mem_req;
  assign pc_wr      = o.pc_wr;
  assign ir_wr      = o.ir_wr;
  assign ab_wr      = o.ab_wr;
  assign aluout_wr  = o.aluout_wr;
  assign dr_wr      = o.dr_wr;
  assign target_wr  = o.target_wr;
  assign dm_wr      = o.dm_wr;
  assign rf_wr      = o.rf_wr;
  assign illegal_op = o.illegal_op;
  assign ext_sz     = o.ext_sz;
  assign alu_a_sel  = o.alu_a_sel;
  assign alu_b_sel  = o.alu_b_sel;
  assign alu_ctrl   = o.alu_ctrl;
  assign rf_w_sel   = o.rf_w_sel;
  assign rf_din_sel = o.rf_din_sel;
  assign pc_sel     = o.pc_sel;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      state <= nxt;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

endmodule
